ps2_host_command_tx: RTL and testbench
======================================

# ps2_host_command_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the FPGA to the keyboard. It runs the full request-to-send sequence: clock inhibit, start bit, 8 data bits, odd parity, stop and device ACK. It shares the PS2_CLK/PS2_DAT lines with the existing scan-code receive path, which must ignore traffic while `busy` is high.

## Interface
- `INHIBIT_CYCLES`, 6000: CLOCK_50 cycles PS2_CLK is held low before the start bit (120 µs).
- `START_TIMEOUT`, 750000: cycles allowed from clock release to the first device falling edge (15 ms).
- `XFER_TIMEOUT`, 100000: cycles allowed from the first device edge to the ACK (2 ms).
- `CLOCK_50`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `the_command`  in  8  byte to send; sampled only when a send is accepted.
- `send_command`  in  1  1-cycle request.
- `PS2_CLK`  inout  1  open-drain: driven 0 or released (z).
- `PS2_DAT`  inout  1  open-drain: driven 0 or released (z).
- `busy`  out  1  high from accept until return to IDLE.
- `command_was_sent`  out  1  1-cycle pulse, ACK received.
- `error_no_ack`  out  1  1-cycle pulse, device left DAT high at ACK.
- `error_communication_timed_out`  out  1  1-cycle pulse, START_TIMEOUT or XFER_TIMEOUT expired.

## Operation
- PS2_CLK and PS2_DAT inputs pass through a 2-flop synchronizer. A falling edge (`fe`) is synced sample 1→0.
- Accept rule: `send_command` is accepted only in IDLE.
  - On accept, latch `the_command` and odd parity `p = ~^the_command`.
  - A request while busy is dropped silently.
- States:
  - IDLE: lines released. On accept, go to INHIBIT.
  - INHIBIT: drive CLK=0 for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: drive DAT=0 (start bit) while CLK is still driven 0, for exactly 1 cycle. Then release CLK, zero the timer and bit counter, and go to WAIT_DEV.
  - WAIT_DEV: hold DAT=0. On the first `fe`, drive bit0 and go to SHIFT with count=1. If the timer reaches START_TIMEOUT, go to ERR.
  - SHIFT: on each `fe`, advance the count and drive the next symbol.
    - Count 1..7 drive data bits 1..7 (LSB first, so bit0 is already out).
    - Count 8 drives `p`.
    - Count 9 releases DAT (stop).
    - Count 10 samples DAT for the ACK and goes to ACK_CHK.
    - If the timer reaches XFER_TIMEOUT, go to ERR.
  - ACK_CHK: if sampled DAT=0, go to WAIT_IDLE with `ack_ok=1`. Otherwise go to WAIT_IDLE with `ack_ok=0`.
  - WAIT_IDLE: wait until synced CLK=1 and DAT=1. Then pulse `command_was_sent` (if `ack_ok`) or `error_no_ack`, and go to IDLE. This wait is also bounded by XFER_TIMEOUT, which goes to ERR.
  - ERR: release both lines, pulse `error_communication_timed_out`, and go to IDLE.
- Line driving: a "1" is always the released line (z), never a driven 1. At most one status pulse fires per accepted command.
- Timer: 20-bit, saturating. It is cleared on entry to INHIBIT, WAIT_DEV and SHIFT, and is not cleared per bit.

## Timing
- Reset values: `busy`=0, all pulses 0, both lines released, state IDLE. This holds on the cycle after `reset` is sampled high, from any state, including mid-frame.
- Accept at cycle T:
  - `busy`=1 and CLK driven low at T+1.
  - DAT driven low at T+1+INHIBIT_CYCLES.
  - CLK released at T+2+INHIBIT_CYCLES.
- Data update latency: the DAT drive changes 1 cycle after a synced `fe`, i.e. 3 CLOCK_50 cycles after the pin edge. This is well inside the ≥5 µs device low phase.
- Status pulse: asserted in the cycle the FSM leaves WAIT_IDLE or ERR. `busy` falls in the same cycle, and a new `send_command` is accepted in the next cycle.
- Simultaneous `fe` and timeout in one cycle: the edge wins.
- Falling edges in IDLE or INHIBIT are ignored.

## Test plan
- 0xED, device model clocks 11 pulses at 12 kHz and ACKs.
  - Required: sampled DAT sequence is start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Required: one `command_was_sent` pulse and `busy` low afterwards.
- 0x01, device ACKs.
  - Required: parity bit 0, `command_was_sent` pulse.
  - Required: CLK low for exactly 6000 cycles before DAT falls.
- Device never clocks.
  - Required: `error_communication_timed_out` pulse 750000 cycles (±2) after CLK release, then both lines z.
- Device clocks 11 edges but leaves DAT high at ACK.
  - Required: `error_no_ack` pulse, no `command_was_sent`.
- `send_command` with 0x55 while sending 0xFF.
  - Required: 0x55 is ignored and 0xFF completes intact.
- `reset` asserted after the 4th data edge.
  - Required: next cycle shows lines z, `busy`=0 and no status pulse.
  - Required: a following 0xF4 send completes normally.

Source files
------------

// File: rtl/ps2_host_command_tx_if.sv
// Command handshake bundle for the PS/2 host transmitter.
// The master issues commands; the slave reports busy and status pulses.
interface ps2_host_command_tx_if;
  logic [7:0] the_command;
  logic       send_command;
  logic       busy;
  logic       command_was_sent;
  logic       error_no_ack;
  logic       error_communication_timed_out;

  modport master (
    output the_command,
    output send_command,
    input  busy,
    input  command_was_sent,
    input  error_no_ack,
    input  error_communication_timed_out
  );

  modport slave (
    input  the_command,
    input  send_command,
    output busy,
    output command_was_sent,
    output error_no_ack,
    output error_communication_timed_out
  );
endinterface

// File: rtl/ps2_host_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send,
// 8 data bits LSB first, odd parity, stop, device ACK check.
module ps2_host_command_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned XFER_TIMEOUT   = 100000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  ps2_host_command_tx_if.slave  bus,
  inout  wire                   PS2_CLK,
  inout  wire                   PS2_DAT
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    WAIT_DEV,
    SHIFT,
    ACK_CHK,
    WAIT_IDLE,
    ERR
  } state_t;

  localparam logic [19:0] INH_LAST  = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] START_LIM = 20'(START_TIMEOUT);
  localparam logic [19:0] XFER_LIM  = 20'(XFER_TIMEOUT);
  localparam logic [19:0] TMAX      = '1;

  state_t      state;
  logic [19:0] timer;
  logic [3:0]  count;
  logic [7:0]  data;
  logic        parity;
  logic        ack_bit;
  logic        ack_ok;
  logic        clk_low;
  logic        dat_low;
  logic [2:0]  clk_sync;
  logic [1:0]  dat_sync;

  // Index 1 is the synced value, index 2 its previous sample.
  logic clk_s;
  logic dat_s;
  logic fe;
  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];
  assign fe    = clk_sync[2] & ~clk_sync[1];

  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[1:0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      count   <= '0;
      data    <= '0;
      parity  <= 1'b0;
      ack_bit <= 1'b1;
      ack_ok  <= 1'b0;
      clk_low <= 1'b0;
      dat_low <= 1'b0;
      bus.busy                          <= 1'b0;
      bus.command_was_sent              <= 1'b0;
      bus.error_no_ack                  <= 1'b0;
      bus.error_communication_timed_out <= 1'b0;
    end else begin
      bus.command_was_sent              <= 1'b0;
      bus.error_no_ack                  <= 1'b0;
      bus.error_communication_timed_out <= 1'b0;
      timer <= (timer == TMAX) ? timer : timer + 20'd1;
      unique case (state)
        IDLE: begin
          if (bus.send_command) begin
            state    <= INHIBIT;
            bus.busy <= 1'b1;
            clk_low  <= 1'b1;
            timer    <= '0;
            data     <= bus.the_command;
            parity   <= ~^bus.the_command;
          end
        end
        INHIBIT: begin
          if (timer == INH_LAST) begin
            state   <= REQ;
            dat_low <= 1'b1;
          end
        end
        REQ: begin
          clk_low <= 1'b0;
          timer   <= '0;
          count   <= '0;
          state   <= WAIT_DEV;
        end
        WAIT_DEV: begin
          if (fe) begin
            dat_low <= ~data[0];
            count   <= 4'd1;
            timer   <= '0;
            state   <= SHIFT;
          end else if (timer >= START_LIM) begin
            dat_low <= 1'b0;
            state   <= ERR;
          end
        end
        SHIFT: begin
          if (fe) begin
            count <= count + 4'd1;
            unique case (1'b1)
              (count <= 4'd7): dat_low <= ~data[count[2:0]];
              (count == 4'd8): dat_low <= ~parity;
              (count == 4'd9): dat_low <= 1'b0;
              default: begin
                ack_bit <= dat_s;
                state   <= ACK_CHK;
              end
            endcase
          end else if (timer >= XFER_LIM) begin
            dat_low <= 1'b0;
            state   <= ERR;
          end
        end
        ACK_CHK: begin
          ack_ok <= ~ack_bit;
          state  <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (clk_s && dat_s) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
            if (ack_ok) bus.command_was_sent <= 1'b1;
            else        bus.error_no_ack     <= 1'b1;
          end else if (timer >= XFER_LIM) begin
            state <= ERR;
          end
        end
        ERR: begin
          clk_low  <= 1'b0;
          dat_low  <= 1'b0;
          bus.busy <= 1'b0;
          bus.error_communication_timed_out <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_command_tx.sv
// Bench for ps2_host_command_tx: vector table, random bytes against a
// frame model, and hand-written timeout / busy-drop / reset sequences.
module tb_ps2_host_command_tx;
  localparam int I    = 200;
  localparam int ST   = 3000;
  localparam int XT   = 2000;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  ps2_host_command_tx_if bus();

  wire  ps2_clk;
  wire  ps2_dat;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);

  ps2_host_command_tx #(
    .INHIBIT_CYCLES(I),
    .START_TIMEOUT (ST),
    .XFER_TIMEOUT  (XT)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .bus     (bus),
    .PS2_CLK (ps2_clk),
    .PS2_DAT (ps2_dat)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_sent = 0;
  int n_nack = 0;
  int n_to   = 0;

  always @(negedge clk) begin
    if (bus.command_was_sent) n_sent <= n_sent + 1;
    if (bus.error_no_ack) n_nack <= n_nack + 1;
    if (bus.error_communication_timed_out) n_to <= n_to + 1;
  end

  typedef struct {
    logic [7:0]  cmd;
    bit          ack;
    logic [10:0] frame;
    bit          sent;
    bit          nack;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  nm, act, act, exp, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.the_command  = b;
    bus.send_command = 1'b1;
    @(negedge clk);
    bus.send_command = 1'b0;
  endtask

  task automatic device(input int np, input bit ack,
                        output logic [10:0] s);
    int w;
    w = 0;
    s = '1;
    while (ps2_clk !== 1'b1 && w < I + 50) begin
      @(negedge clk);
      w++;
    end
    chk("clk_released", int'(ps2_clk === 1'b1), 1);
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < np; i++) begin
      s[i] = ps2_dat;
      if (i == 10 && ack) dev_dat_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < XT + 100) begin
      @(negedge clk);
      n++;
    end
    chk("busy_falls", int'(bus.busy), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input bit ack,
                           input logic [10:0] ef,
                           input bit es, input bit en);
    int s0, n0, t0, ni;
    logic [10:0] s;
    s0 = n_sent; n0 = n_nack; t0 = n_to;
    send(cmd);
    chk("busy_on_accept", int'(bus.busy), 1);
    chk("clk_low_on_accept", int'(ps2_clk === 1'b0), 1);
    ni = 0;
    while (ps2_clk === 1'b0 && ps2_dat === 1'b1 && ni < I + 50) begin
      ni++;
      @(negedge clk);
    end
    chk("inhibit_len", ni, I);
    chk("start_bit_with_clk_low",
        int'(ps2_clk === 1'b0 && ps2_dat === 1'b0), 1);
    device(11, ack, s);
    chk("frame_bits", int'(s), int'(ef));
    wait_idle();
    chk("sent_pulses", n_sent - s0, int'(es));
    chk("nack_pulses", n_nack - n0, int'(en));
    chk("to_pulses", n_to - t0, 0);
    chk("lines_released", int'(ps2_clk === 1'b1 && ps2_dat === 1'b1), 1);
  endtask

  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(b[k]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  initial begin
    logic [10:0] s;
    int s0, n0, t0, w, n;
    logic [7:0] rb;
    bit ra;

    tbl[0] = '{8'hED, 1'b1, 11'b1_1_1110_1101_0, 1'b1, 1'b0};
    tbl[1] = '{8'h01, 1'b1, 11'b1_0_0000_0001_0, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 11'b1_1_0011_1100_0, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 1'b1, 11'b1_1_0000_0000_0, 1'b1, 1'b0};

    bus.the_command  = 8'h00;
    bus.send_command = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_lines", int'(ps2_clk === 1'b1 && ps2_dat === 1'b1), 1);
    chk("reset_pulses", int'(bus.command_was_sent | bus.error_no_ack |
                            bus.error_communication_timed_out), 0);

    for (int i = 0; i < 4; i++)
      run_frame(tbl[i].cmd, tbl[i].ack, tbl[i].frame,
                tbl[i].sent, tbl[i].nack);

    // Request while busy is dropped; 0xFF must go out intact.
    s0 = n_sent;
    send(8'hFF);
    fork
      device(11, 1'b1, s);
      begin
        repeat (I + 150) @(negedge clk);
        bus.the_command  = 8'h55;
        bus.send_command = 1'b1;
        @(negedge clk);
        bus.send_command = 1'b0;
      end
    join
    wait_idle();
    chk("busy_drop_frame", int'(s), int'(11'b1_1_1111_1111_0));
    chk("busy_drop_sent", n_sent - s0, 1);
    repeat (20) @(negedge clk);
    chk("busy_drop_no_retry", int'(bus.busy), 0);

    // Device never clocks.
    s0 = n_sent; n0 = n_nack; t0 = n_to;
    send(8'h12);
    w = 0;
    while (ps2_clk !== 1'b1 && w < I + 50) begin
      @(negedge clk);
      w++;
    end
    n = 0;
    while (!bus.error_communication_timed_out && n < ST + 50) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_window", int'(n >= ST - 2 && n <= ST + 2), 1);
    if (n < ST - 2 || n > ST + 2)
      $display("FAIL timeout_latency: got %0d expected %0d +-2", n, ST);
    chk("timeout_lines", int'(ps2_clk === 1'b1 && ps2_dat === 1'b1), 1);
    chk("timeout_busy", int'(bus.busy), 0);
    repeat (3) @(negedge clk);
    chk("timeout_pulses", n_to - t0, 1);
    chk("timeout_other", (n_sent - s0) + (n_nack - n0), 0);

    // Reset mid-frame, after the 4th data edge.
    s0 = n_sent; n0 = n_nack; t0 = n_to;
    send(8'hA5);
    device(5, 1'b0, s);
    chk("pre_reset_busy", int'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_lines", int'(ps2_clk === 1'b1 && ps2_dat === 1'b1), 1);
    chk("midreset_busy", int'(bus.busy), 0);
    chk("midreset_pulse", int'(bus.command_was_sent | bus.error_no_ack |
                              bus.error_communication_timed_out), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_no_pulses",
        (n_sent - s0) + (n_nack - n0) + (n_to - t0), 0);
    run_frame(8'hF4, 1'b1, 11'b1_0_1111_0100_0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      ra = ($urandom_range(3) != 0);
      run_frame(rb, ra, model_frame(rb), ra, !ra);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
